// File: rtl/pipe_regs_pkg.sv
// Shared constants for MCU datapath pipeline registers (stage payload widths, NOP fill value)
// and the occupancy-counter width helper used by pipe_regs.
package pipe_regs_pkg;

    localparam int PIPE_FD_WIDTH = 16;
    localparam int PIPE_DE_WIDTH = 32;

    // addi x0,x0,0: a harmless fill value for instruction-carrying stages
    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_regs_stage.sv
// One pipeline slot: valid flag plus payload register, advancing when the
// downstream slot frees up. Data only loads on a valid item so bubbles do not toggle it.
module pipe_stage
    import pipe_regs_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_prev_valid,
    input  logic [WIDTH-1:0] i_prev_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_prev_valid;
            if (i_prev_valid) begin
                r_data <= i_prev_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_regs.sv
// Valid/ready pipeline register chain with bubble collapsing and synchronous flush.
// Define PIPE_REGS_COUNT_EN to add the registered o_count occupancy output.
module pipe_regs
    import pipe_regs_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
`ifdef PIPE_REGS_COUNT_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] o_count
`endif
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pipe_regs: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_prev_v;
    logic [WIDTH-1:0] w_d      [DEPTH];
    logic [WIDTH-1:0] w_prev_d [DEPTH];

    // A slot may advance if the slot after it advances or it holds a bubble
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = i_out_ready | ~w_v[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = w_adv[i+1] | ~w_v[i];
        end
    end

    assign w_prev_v[0] = i_in_valid;
    assign w_prev_d[0] = i_in_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi > 0) begin : g_link
            assign w_prev_v[gi] = w_v[gi-1];
            assign w_prev_d[gi] = w_d[gi-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_flush      (i_flush),
            .i_adv        (w_adv[gi]),
            .i_prev_valid (w_prev_v[gi]),
            .i_prev_data  (w_prev_d[gi]),
            .o_valid      (w_v[gi]),
            .o_data       (w_d[gi])
        );
    end

    assign o_in_ready  = w_adv[0] & ~i_flush;
    assign o_out_valid = w_v[DEPTH-1];
    assign o_out_data  = w_d[DEPTH-1];

`ifdef PIPE_REGS_COUNT_EN
    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    // Population count of the valid flags as they will be after this edge
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_adv[i] ? w_prev_v[i] : w_v[i]) begin
                w_count_nxt = w_count_nxt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;
`endif

endmodule
